// File: rtl/rom_fetch_arbiter.sv
// rtl/rom_fetch_arbiter.sv - PC sequencer and fetch/debug arbiter for a shared combinational ROM port
//
// Ports:
//   Clock, Reset          : rising-edge clock, synchronous active-high reset
//   iStall                : execute stage not ready, hold the current instruction
//   iBranchTaken/Target   : redirect fetch this cycle (beats iStall)
//   oROMAddress           : combinational ROM address (debug or fetch)
//   iROMInstruction       : same-cycle ROM data
//   oInstruction/oPC      : registered fetched instruction and its address
//   oInstrValid           : oInstruction holds a valid fetch
//   iDbgReq/iDbgAddress   : level debug read request and address
//   oDbgGrant             : ROM port owned by debug this cycle
//   oDbgInstruction       : registered debug read data
//   oDbgValid             : one-cycle pulse the cycle after each grant
module rom_fetch_arbiter #(
    parameter logic [15:0] RESET_PC    = 16'd0,
    parameter int          MAX_DBG_RUN = 4,
    parameter logic [27:0] NOP_WORD    = 28'd0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    output logic [15:0] oROMAddress,
    input  logic [27:0] iROMInstruction,
    output logic [27:0] oInstruction,
    output logic        oInstrValid,
    output logic [15:0] oPC,
    input  logic        iDbgReq,
    input  logic [15:0] iDbgAddress,
    output logic        oDbgGrant,
    output logic [27:0] oDbgInstruction,
    output logic        oDbgValid
);

    localparam int                CNT_W   = $clog2(MAX_DBG_RUN + 1);
    localparam logic [CNT_W-1:0]  RUN_MAX = CNT_W'(MAX_DBG_RUN);

    logic [15:0]      pc_q, pc_d;
    logic [27:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [15:0]      opc_q, opc_d;
    logic [27:0]      dinstr_q, dinstr_d;
    logic             dvalid_q, dvalid_d;
    logic [CNT_W-1:0] run_q, run_d;

    logic             eff_stall;
    logic             dbg_grant;
    logic             fetch_en;
    logic [15:0]      fetch_addr;

    always_comb begin
        // A redirect must always be taken, so it overrides a stall.
        eff_stall  = iStall & ~iBranchTaken;
        // A stalled fetch loses nothing by yielding, so debug is always
        // granted then; otherwise debug may only take a bounded run.
        dbg_grant  = ~Reset & iDbgReq & (eff_stall | (run_q < RUN_MAX));
        fetch_addr = iBranchTaken ? iBranchTarget : pc_q;
        fetch_en   = ~dbg_grant & ~eff_stall;

        oROMAddress = Reset ? RESET_PC : (dbg_grant ? iDbgAddress : fetch_addr);
        oDbgGrant   = dbg_grant;

        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        opc_d    = opc_q;
        dinstr_d = dinstr_q;
        dvalid_d = 1'b0;
        run_d    = run_q;

        if (dbg_grant) begin
            dinstr_d = iROMInstruction;
            dvalid_d = 1'b1;
            if (iBranchTaken) begin
                // Redirect is latched so the next fetch reads the target.
                pc_d    = iBranchTarget;
                valid_d = 1'b0;
            end else if (!eff_stall) begin
                valid_d = 1'b0;
            end
        end else if (fetch_en) begin
            instr_d = iROMInstruction;
            opc_d   = fetch_addr;
            valid_d = 1'b1;
            pc_d    = fetch_addr + 16'd1;
        end

        if (!iDbgReq || fetch_en) begin
            run_d = '0;
        end else if (dbg_grant && !eff_stall && (run_q != RUN_MAX)) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            opc_q    <= RESET_PC;
            dinstr_q <= '0;
            dvalid_q <= 1'b0;
            run_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            opc_q    <= opc_d;
            dinstr_q <= dinstr_d;
            dvalid_q <= dvalid_d;
            run_q    <= run_d;
        end
    end

    assign oInstruction    = instr_q;
    assign oInstrValid     = valid_q;
    assign oPC             = opc_q;
    assign oDbgInstruction = dinstr_q;
    assign oDbgValid       = dvalid_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb/tb_rom_fetch_arbiter.sv - self-checking bench for rom_fetch_arbiter
module tb_rom_fetch_arbiter;

    localparam logic [15:0] RESET_PC    = 16'd0;
    localparam int          MAX_DBG_RUN = 4;
    localparam logic [27:0] NOP_WORD    = 28'd0;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iStall = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [15:0] iBranchTarget = 16'd0;
    logic [15:0] oROMAddress;
    logic [27:0] iROMInstruction;
    logic [27:0] oInstruction;
    logic        oInstrValid;
    logic [15:0] oPC;
    logic        iDbgReq = 1'b0;
    logic [15:0] iDbgAddress = 16'd0;
    logic        oDbgGrant;
    logic [27:0] oDbgInstruction;
    logic        oDbgValid;

    int passed = 0;
    int total  = 0;

    // Reference state
    logic [15:0] m_pc    = RESET_PC;
    logic [27:0] m_instr = NOP_WORD;
    logic        m_valid = 1'b0;
    logic [15:0] m_opc   = RESET_PC;
    logic [27:0] m_dinstr = 28'd0;
    logic        m_dvalid = 1'b0;
    int          m_run   = 0;
    logic        g_seen;

    always #5 Clock = ~Clock;

    function automatic logic [27:0] romf(input logic [15:0] a);
        return {a[11:0] ^ 12'h5A3, a};
    endfunction

    assign iROMInstruction = romf(oROMAddress);

    rom_fetch_arbiter #(
        .RESET_PC(RESET_PC),
        .MAX_DBG_RUN(MAX_DBG_RUN),
        .NOP_WORD(NOP_WORD)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iStall(iStall),
        .iBranchTaken(iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .oROMAddress(oROMAddress),
        .iROMInstruction(iROMInstruction),
        .oInstruction(oInstruction),
        .oInstrValid(oInstrValid),
        .oPC(oPC),
        .iDbgReq(iDbgReq),
        .iDbgAddress(iDbgAddress),
        .oDbgGrant(oDbgGrant),
        .oDbgInstruction(oDbgInstruction),
        .oDbgValid(oDbgValid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: drive inputs, check combinational outputs, advance the
    // reference by the arbitration rules, then check registered outputs.
    task automatic cycle(input logic rst, input logic stall, input logic br,
                         input logic [15:0] tgt, input logic req, input logic [15:0] daddr);
        logic        eff, grant, fetch;
        logic [15:0] fa, addr;
        logic [27:0] data;
        Reset = rst; iStall = stall; iBranchTaken = br; iBranchTarget = tgt;
        iDbgReq = req; iDbgAddress = daddr;
        #1;
        eff   = stall & ~br;
        grant = !rst && req && (eff || m_run < MAX_DBG_RUN);
        fa    = br ? tgt : m_pc;
        addr  = rst ? RESET_PC : (grant ? daddr : fa);
        fetch = !grant && !eff;
        chk("grant", oDbgGrant, grant);
        chk("rom_addr", oROMAddress, addr);
        g_seen = oDbgGrant;
        data = romf(addr);
        if (rst) begin
            m_pc = RESET_PC; m_instr = NOP_WORD; m_valid = 0; m_opc = RESET_PC;
            m_dinstr = 0; m_dvalid = 0; m_run = 0;
        end else begin
            m_dvalid = grant;
            if (grant) begin
                m_dinstr = data;
                if (br) begin m_pc = tgt; m_valid = 0; end
                else if (!eff) m_valid = 0;
            end else if (fetch) begin
                m_instr = data; m_opc = fa; m_valid = 1; m_pc = fa + 16'd1;
            end
            if (!req || fetch) m_run = 0;
            else if (grant && !eff) m_run = (m_run + 1 > MAX_DBG_RUN) ? MAX_DBG_RUN : m_run + 1;
        end
        @(posedge Clock);
        #1;
        chk("instr", oInstruction, m_instr);
        chk("instr_valid", oInstrValid, m_valid);
        chk("opc", oPC, m_opc);
        chk("dbg_instr", oDbgInstruction, m_dinstr);
        chk("dbg_valid", oDbgValid, m_dvalid);
    endtask

    initial begin
        logic [9:0] pat;
        @(posedge Clock);
        #1;
        // Reset, with a debug request that must not be granted
        cycle(1, 0, 0, 16'h0, 1, 16'h55);
        cycle(1, 0, 0, 16'h0, 1, 16'h55);
        chk("rst_opc", oPC, 16'h0);
        chk("rst_valid", oInstrValid, 0);
        chk("rst_instr", oInstruction, 28'h0);

        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 16'h0, 0, 16'h0);
            chk("seq_opc", oPC, i);
            chk("seq_valid", oInstrValid, 1);
            chk("seq_instr_lo", oInstruction[15:0], i);
        end
        cycle(0, 0, 0, 16'h0, 0, 16'h0);
        chk("opc4", oPC, 16'd4);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 16'h0, 0, 16'h0);
            chk("stall_opc", oPC, 16'd4);
            chk("stall_instr_lo", oInstruction[15:0], 16'd4);
        end
        cycle(0, 0, 0, 16'h0, 0, 16'h0);
        chk("post_stall_opc", oPC, 16'd5);

        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 16'h0, 0, 16'h0);
        chk("opc11", oPC, 16'd11);
        cycle(0, 0, 1, 16'd8, 0, 16'h0);
        chk("br_opc", oPC, 16'd8);
        chk("br_instr_lo", oInstruction[15:0], 16'd8);
        cycle(0, 0, 0, 16'h0, 0, 16'h0);
        chk("br_opc9", oPC, 16'd9);
        cycle(0, 0, 0, 16'h0, 0, 16'h0);
        chk("br_opc10", oPC, 16'd10);
        cycle(0, 1, 1, 16'd8, 0, 16'h0);
        chk("br_stall_opc", oPC, 16'd8);

        // Bounded debug run: 1,1,1,1,0,1,1,1,1,0
        pat = 10'b0111101111;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 16'h0, 1, 16'd100);
            chk("dbg_pat", g_seen, pat[i]);
            if (pat[i]) begin
                chk("dbg_data_lo", oDbgInstruction[15:0], 16'd100);
                chk("dbg_pulse", oDbgValid, 1);
            end
            if (i == 4) chk("forced_opc9", oPC, 16'd9);
        end
        chk("forced_opc10", oPC, 16'd10);

        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0, 16'h0, 1, 16'd33);
            chk("stall_dbg_grant", g_seen, 1);
            chk("stall_dbg_opc", oPC, 16'd10);
        end
        cycle(0, 0, 0, 16'h0, 0, 16'h0);
        chk("resume_opc", oPC, 16'd11);

        cycle(0, 0, 1, 16'hFFFF, 0, 16'h0);
        chk("wrap_ffff", oPC, 16'hFFFF);
        cycle(0, 0, 0, 16'h0, 0, 16'h0);
        chk("wrap_0000", oPC, 16'h0000);
        cycle(0, 0, 0, 16'h0, 0, 16'h0);
        chk("wrap_0001", oPC, 16'h0001);

        // Reset in the middle of a debug burst, with a redirect present
        cycle(0, 0, 0, 16'h0, 1, 16'd200);
        cycle(0, 0, 0, 16'h0, 1, 16'd200);
        cycle(1, 0, 1, 16'h1234, 1, 16'd200);
        chk("midrst_dvalid", oDbgValid, 0);
        chk("midrst_dinstr", oDbgInstruction, 28'h0);
        chk("midrst_opc", oPC, 16'h0);
        chk("midrst_valid", oInstrValid, 0);
        cycle(0, 0, 0, 16'h0, 0, 16'h0);
        chk("midrst_first", oPC, 16'h0);

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(2) == 0), ($urandom_range(7) == 0),
                  16'($urandom), ($urandom_range(1) == 1), 16'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
